decode_instr_assembler: RTL and testbench

//  Parametrised successor to the single-slot decode collater. Sits between the decode input

---
 rtl/decode_instr_assembler.sv | 141 ++++++++++++++
 tb/tb_decode_instr_assembler.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_instr_assembler.sv
// Decode instruction assembler: gathers multi-dword instructions per wavefront
// slot so dwords of different wavefronts may interleave, with per-slot flush.
module decode_instr_assembler #(
  parameter int NUM_WF     = 40,
  parameter int WFID_W     = 6,
  parameter int MAX_DWORDS = 2,
  parameter int CNT_W      = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WFID_W-1:0]        in_wfid,
  input  logic [31:0]              in_instr,
  input  logic [31:0]              in_pc,
  input  logic [CNT_W-1:0]         in_need,
  input  logic                     flush_valid,
  input  logic [WFID_W-1:0]        flush_wfid,
  output logic                     out_valid,
  output logic [WFID_W-1:0]        out_wfid,
  output logic [32*MAX_DWORDS-1:0] out_instr,
  output logic [31:0]              out_pc,
  output logic [CNT_W-1:0]         out_ndwords,
  output logic                     half_rqd,
  output logic [WFID_W-1:0]        half_wfid,
  output logic [NUM_WF-1:0]        pending_vec,
  output logic                     err_need
);

  localparam int               IW       = 32 * MAX_DWORDS;
  localparam logic [31:0]      NUM_WF_U = NUM_WF;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_DWORDS);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } slot_state_t;

  // Per-slot control (reset) and payload (not reset).
  slot_state_t       state_q [NUM_WF];
  logic [CNT_W-1:0]  cnt_q   [NUM_WF];
  logic [CNT_W-1:0]  need_q  [NUM_WF];
  logic [31:0]       pc_q    [NUM_WF];
  logic [IW-1:0]     dw_q    [NUM_WF];

  logic              in_range;
  logic              flush_ok;
  logic              in_ok;
  logic [WFID_W-1:0] wf_idx;
  logic              busy;
  logic              need_bad;
  logic [CNT_W-1:0]  eff_need;
  logic [CNT_W-1:0]  cur_cnt;
  logic [CNT_W-1:0]  tgt_need;
  logic              complete;
  logic [31:0]       asm_pc;
  logic [IW-1:0]     asm_instr;
  slot_state_t       slot_next;

  // Decode the incoming dword against its slot: acceptance, completion, assembly.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    in_range  = in_valid && (32'(in_wfid) < NUM_WF_U);
    flush_ok  = flush_valid && (32'(flush_wfid) < NUM_WF_U);
    // A flush of the same slot wins over the dword arriving with it.
    in_ok     = in_range && !(flush_ok && (flush_wfid == in_wfid));
    wf_idx    = in_range ? in_wfid : '0;
    busy      = (state_q[wf_idx] == COLLECT);
    need_bad  = (in_need == '0) || (in_need > MAX_CNT);
    eff_need  = (in_need == '0) ? CNT_W'(1) : ((in_need > MAX_CNT) ? MAX_CNT : in_need);
    cur_cnt   = busy ? cnt_q[wf_idx] : '0;
    tgt_need  = busy ? need_q[wf_idx] : eff_need;
    complete  = ((cur_cnt + CNT_W'(1)) == tgt_need);
    asm_pc    = busy ? pc_q[wf_idx] : in_pc;
    asm_instr = '0;
    for (int k = 0; k < MAX_DWORDS; k++) begin
      if (CNT_W'(k) < cur_cnt)       asm_instr[32*k +: 32] = dw_q[wf_idx][32*k +: 32];
      else if (CNT_W'(k) == cur_cnt) asm_instr[32*k +: 32] = in_instr;
    end
    slot_next = complete ? IDLE : COLLECT;
    half_rqd  = in_ok && !complete;
    half_wfid = in_wfid;
  end

  // Expose which slots hold a partial instruction.
  always_comb begin
    pending_vec = '0;
    for (int w = 0; w < NUM_WF; w++) pending_vec[w] = (state_q[w] == COLLECT);
  end

  // Slot state register: advance the addressed slot, then apply any flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < NUM_WF; w++) begin
        state_q[w] <= IDLE;
        cnt_q[w]   <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every register update order-independent.
      if (in_ok) begin
        state_q[wf_idx] <= slot_next;
        cnt_q[wf_idx]   <= complete ? '0 : cur_cnt + CNT_W'(1);
      end
      if (flush_ok) begin
        state_q[flush_wfid] <= IDLE;
        cnt_q[flush_wfid]   <= '0;
      end
    end
  end

  // Slot payload: capture the partial instruction while it is still incomplete.
  always_ff @(posedge clk) begin
    // NOTE: payload storage has no reset; it is only read while its slot is COLLECT.
    if (in_ok && !complete) begin
      dw_q[wf_idx]   <= asm_instr;
      pc_q[wf_idx]   <= asm_pc;
      need_q[wf_idx] <= tgt_need;
    end
  end

  // Registered issue port: one-cycle valid pulse, data held between issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_wfid    <= '0;
      out_instr   <= '0;
      out_pc      <= '0;
      out_ndwords <= '0;
      err_need    <= 1'b0;
    end else begin
      out_valid <= in_ok && complete;
      err_need  <= in_ok && !busy && need_bad;
      if (in_ok && complete) begin
        out_wfid    <= in_wfid;
        out_instr   <= asm_instr;
        out_pc      <= asm_pc;
        out_ndwords <= cur_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_decode_instr_assembler.sv
// Directed bench for decode_instr_assembler: a vector table on a MAX_DWORDS=2
// instance plus hand sequences for reset and a MAX_DWORDS=3 instance.
module tb_decode_instr_assembler;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [5:0]  in_wfid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [2:0]  in_need;
  logic        flush_valid;
  logic [5:0]  flush_wfid;

  logic        o2_valid, o2_half, o2_err;
  logic [5:0]  o2_wfid, o2_hwfid;
  logic [63:0] o2_instr;
  logic [31:0] o2_pc;
  logic [2:0]  o2_nd;
  logic [39:0] o2_pend;

  logic        o3_valid, o3_half, o3_err;
  logic [5:0]  o3_wfid, o3_hwfid;
  logic [95:0] o3_instr;
  logic [31:0] o3_pc;
  logic [2:0]  o3_nd;
  logic [39:0] o3_pend;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_instr_assembler #(.NUM_WF(40), .WFID_W(6), .MAX_DWORDS(2), .CNT_W(3)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_wfid(in_wfid), .in_instr(in_instr),
    .in_pc(in_pc), .in_need(in_need), .flush_valid(flush_valid), .flush_wfid(flush_wfid),
    .out_valid(o2_valid), .out_wfid(o2_wfid), .out_instr(o2_instr), .out_pc(o2_pc),
    .out_ndwords(o2_nd), .half_rqd(o2_half), .half_wfid(o2_hwfid), .pending_vec(o2_pend),
    .err_need(o2_err)
  );

  decode_instr_assembler #(.NUM_WF(40), .WFID_W(6), .MAX_DWORDS(3), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_wfid(in_wfid), .in_instr(in_instr),
    .in_pc(in_pc), .in_need(in_need), .flush_valid(flush_valid), .flush_wfid(flush_wfid),
    .out_valid(o3_valid), .out_wfid(o3_wfid), .out_instr(o3_instr), .out_pc(o3_pc),
    .out_ndwords(o3_nd), .half_rqd(o3_half), .half_wfid(o3_hwfid), .pending_vec(o3_pend),
    .err_need(o3_err)
  );

  typedef struct {
    logic        v;
    logic [5:0]  wf;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  need;
    logic        fv;
    logic [5:0]  fwf;
    logic        e_half;
    logic        e_ov;
    logic [5:0]  e_wf;
    logic [63:0] e_instr;
    logic [31:0] e_pc;
    logic [2:0]  e_nd;
    logic        e_err;
    logic [39:0] e_pend;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  // Last issued instruction: out_* data must hold it while out_valid is low.
  logic [5:0]  last_wf;
  logic [63:0] last_instr;
  logic [31:0] last_pc;
  logic [2:0]  last_nd;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] wf, input logic [31:0] instr,
                       input logic [31:0] pc, input logic [2:0] need,
                       input logic fv, input logic [5:0] fwf);
    @(negedge clk);
    in_valid    = v;
    in_wfid     = wf;
    in_instr    = instr;
    in_pc       = pc;
    in_need     = need;
    flush_valid = fv;
    flush_wfid  = fwf;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_wfid = '0; in_instr = '0; in_pc = '0; in_need = '0;
    flush_valid = 1'b0; flush_wfid = '0;
    step();
    step();
    check("reset_ov2",   {127'd0, o2_valid}, 128'd0);
    check("reset_data2", {o2_instr, o2_pc, o2_wfid, o2_nd}, 128'd0);
    check("reset_pend2", {88'd0, o2_pend}, 128'd0);
    check("reset_pend3", {88'd0, o3_pend}, 128'd0);
    drive(1'b0, 6'd0, 32'h0, 32'h0, 3'd0, 1'b0, 6'd0);
    rst = 1'b0;

    //          v     wf     instr          pc        need  fv    fwf     half  ov    e_wf    e_instr                  e_pc      nd    err   pend
    vecs[0]  = '{1'b1, 6'd3,  32'hBF810000, 32'h100, 3'd1, 1'b0, 6'd0,  1'b0, 1'b1, 6'd3,  64'h00000000_BF810000, 32'h100, 3'd1, 1'b0, 40'h0};
    vecs[1]  = '{1'b1, 6'd1,  32'hAAAA0001, 32'h040, 3'd2, 1'b0, 6'd0,  1'b1, 1'b0, 6'd0,  64'h0,                 32'h0,   3'd0, 1'b0, 40'h2};
    vecs[2]  = '{1'b1, 6'd2,  32'h22220002, 32'h080, 3'd1, 1'b0, 6'd0,  1'b0, 1'b1, 6'd2,  64'h00000000_22220002, 32'h080, 3'd1, 1'b0, 40'h2};
    vecs[3]  = '{1'b1, 6'd1,  32'hBBBB0002, 32'h044, 3'd0, 1'b0, 6'd0,  1'b0, 1'b1, 6'd1,  64'hBBBB0002_AAAA0001, 32'h040, 3'd2, 1'b0, 40'h0};
    vecs[4]  = '{1'b1, 6'd5,  32'h55550001, 32'h1C0, 3'd2, 1'b0, 6'd0,  1'b1, 1'b0, 6'd0,  64'h0,                 32'h0,   3'd0, 1'b0, 40'h20};
    vecs[5]  = '{1'b0, 6'd0,  32'h0,        32'h0,   3'd0, 1'b1, 6'd5,  1'b0, 1'b0, 6'd0,  64'h0,                 32'h0,   3'd0, 1'b0, 40'h0};
    vecs[6]  = '{1'b1, 6'd5,  32'h55550002, 32'h200, 3'd1, 1'b0, 6'd0,  1'b0, 1'b1, 6'd5,  64'h00000000_55550002, 32'h200, 3'd1, 1'b0, 40'h0};
    vecs[7]  = '{1'b1, 6'd7,  32'h77770001, 32'h300, 3'd2, 1'b0, 6'd0,  1'b1, 1'b0, 6'd0,  64'h0,                 32'h0,   3'd0, 1'b0, 40'h80};
    vecs[8]  = '{1'b1, 6'd7,  32'h77770002, 32'h304, 3'd1, 1'b1, 6'd7,  1'b0, 1'b0, 6'd0,  64'h0,                 32'h0,   3'd0, 1'b0, 40'h0};
    vecs[9]  = '{1'b1, 6'd7,  32'h77770003, 32'h310, 3'd1, 1'b0, 6'd0,  1'b0, 1'b1, 6'd7,  64'h00000000_77770003, 32'h310, 3'd1, 1'b0, 40'h0};
    vecs[10] = '{1'b1, 6'd9,  32'h99990001, 32'h400, 3'd0, 1'b0, 6'd0,  1'b0, 1'b1, 6'd9,  64'h00000000_99990001, 32'h400, 3'd1, 1'b1, 40'h0};
    vecs[11] = '{1'b1, 6'd10, 32'hAAAA1001, 32'h500, 3'd3, 1'b0, 6'd0,  1'b1, 1'b0, 6'd0,  64'h0,                 32'h0,   3'd0, 1'b1, 40'h400};
    vecs[12] = '{1'b1, 6'd11, 32'hBBBB1101, 32'h600, 3'd1, 1'b1, 6'd10, 1'b0, 1'b1, 6'd11, 64'h00000000_BBBB1101, 32'h600, 3'd1, 1'b0, 40'h0};
    vecs[13] = '{1'b1, 6'd45, 32'hCCCC0001, 32'h700, 3'd2, 1'b0, 6'd0,  1'b0, 1'b0, 6'd0,  64'h0,                 32'h0,   3'd0, 1'b0, 40'h0};
    vecs[14] = '{1'b0, 6'd0,  32'h0,        32'h0,   3'd0, 1'b1, 6'd3,  1'b0, 1'b0, 6'd0,  64'h0,                 32'h0,   3'd0, 1'b0, 40'h0};

    last_wf = '0; last_instr = '0; last_pc = '0; last_nd = '0;
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].v, vecs[i].wf, vecs[i].instr, vecs[i].pc, vecs[i].need, vecs[i].fv, vecs[i].fwf);
      #1;
      check($sformatf("v%0d_half", i), {127'd0, o2_half}, {127'd0, vecs[i].e_half});
      step();
      if (vecs[i].e_ov) begin
        last_wf = vecs[i].e_wf; last_instr = vecs[i].e_instr;
        last_pc = vecs[i].e_pc; last_nd = vecs[i].e_nd;
      end
      check($sformatf("v%0d_ov", i),    {127'd0, o2_valid}, {127'd0, vecs[i].e_ov});
      check($sformatf("v%0d_wfid", i),  {122'd0, o2_wfid},  {122'd0, last_wf});
      check($sformatf("v%0d_instr", i), {64'd0, o2_instr},  {64'd0, last_instr});
      check($sformatf("v%0d_pc", i),    {96'd0, o2_pc},     {96'd0, last_pc});
      check($sformatf("v%0d_nd", i),    {125'd0, o2_nd},    {125'd0, last_nd});
      check($sformatf("v%0d_err", i),   {127'd0, o2_err},   {127'd0, vecs[i].e_err});
      check($sformatf("v%0d_pend", i),  {88'd0, o2_pend},   {88'd0, vecs[i].e_pend});
    end

    // Reset in the middle of a collect on wf4, then a fresh single-dword issue.
    drive(1'b1, 6'd4, 32'h44440001, 32'h800, 3'd2, 1'b0, 6'd0);
    #1;
    check("hwfid", {122'd0, o2_hwfid}, 128'd4);
    step();
    check("rst_pre_pend", {88'd0, o2_pend}, 128'h10);
    drive(1'b0, 6'd0, 32'h0, 32'h0, 3'd0, 1'b0, 6'd0);
    rst = 1'b1;
    step();
    check("rst_ov",   {127'd0, o2_valid}, 128'd0);
    check("rst_data", {o2_instr, o2_pc, o2_wfid, o2_nd}, 128'd0);
    check("rst_pend", {88'd0, o2_pend}, 128'd0);
    check("rst_err",  {127'd0, o2_err}, 128'd0);
    drive(1'b1, 6'd4, 32'h44440009, 32'h900, 3'd1, 1'b0, 6'd0);
    rst = 1'b0;
    #1;
    check("post_rst_half", {127'd0, o2_half}, 128'd0);
    step();
    check("post_rst_ov",    {127'd0, o2_valid}, 128'd1);
    check("post_rst_instr", {64'd0, o2_instr}, {64'd0, 64'h00000000_44440009});
    check("post_rst_pc",    {96'd0, o2_pc}, 128'h900);
    check("post_rst_nd",    {125'd0, o2_nd}, 128'd1);

    // MAX_DWORDS=3: three-dword instruction, then need=5 clamped to 3.
    drive(1'b1, 6'd0, 32'h0000_000A, 32'hA00, 3'd3, 1'b0, 6'd0);
    #1;
    check("m3_x_half", {127'd0, o3_half}, 128'd1);
    drive(1'b1, 6'd0, 32'h0000_000B, 32'hA04, 3'd1, 1'b0, 6'd0);
    #1;
    check("m3_y_half", {127'd0, o3_half}, 128'd1);
    check("m3_y_pend", {88'd0, o3_pend}, 128'd1);
    drive(1'b1, 6'd0, 32'h0000_000C, 32'hA08, 3'd1, 1'b0, 6'd0);
    #1;
    check("m3_z_half", {127'd0, o3_half}, 128'd0);
    step();
    check("m3_ov",    {127'd0, o3_valid}, 128'd1);
    check("m3_instr", {32'd0, o3_instr}, {32'd0, 96'h0000000C_0000000B_0000000A});
    check("m3_pc",    {96'd0, o3_pc}, 128'hA00);
    check("m3_nd",    {125'd0, o3_nd}, 128'd3);
    check("m3_pend",  {88'd0, o3_pend}, 128'd0);

    drive(1'b1, 6'd2, 32'h0000_0011, 32'hB00, 3'd5, 1'b0, 6'd0);
    #1;
    check("m3_p_half", {127'd0, o3_half}, 128'd1);
    step();
    check("m3_p_err",  {127'd0, o3_err}, 128'd1);
    check("m3_p_pend", {88'd0, o3_pend}, 128'h4);
    drive(1'b1, 6'd2, 32'h0000_0022, 32'hB04, 3'd5, 1'b0, 6'd0);
    step();
    check("m3_q_err", {127'd0, o3_err}, 128'd0);
    check("m3_q_ov",  {127'd0, o3_valid}, 128'd0);
    drive(1'b1, 6'd2, 32'h0000_0033, 32'hB08, 3'd5, 1'b0, 6'd0);
    step();
    check("m3_r_ov",    {127'd0, o3_valid}, 128'd1);
    check("m3_r_instr", {32'd0, o3_instr}, {32'd0, 96'h00000033_00000022_00000011});
    check("m3_r_pc",    {96'd0, o3_pc}, 128'hB00);
    check("m3_r_nd",    {125'd0, o3_nd}, 128'd3);
    drive(1'b0, 6'd0, 32'h0, 32'h0, 3'd0, 1'b0, 6'd0);
    step();
    check("m3_pulse_end", {127'd0, o3_valid}, 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
